pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Parametrised hazard controller for the 5-stage ARM pipeline (F/D/E/M/W). It sits beside the control path and datapath and generates operand-forwarding selects, load-use stalls and branch/PC-write flushes. It also freezes the pipeline while a variable-latency data memory is not ready, aborts memory accesses that exceed a timeout, and keeps saturating stall/flush statistics.

## Interface
Parameters:
- REG_AW, 4, register-address width
- PC_REG, 15, register index never forwarded (PC read path handled in datapath)
- MEM_TIMEOUT, 16, max consecutive memory-stall cycles before abort (≥2)
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- ra1d, ra2d  in  REG_AW  D-stage source registers
- ra1e, ra2e  in  REG_AW  E-stage source registers
- wa3e, wa3m, wa3w  in  REG_AW  destination register in E/M/W
- regwrite_m, regwrite_w  in  1  M/W instruction writes register file
- memtoreg_e  in  1  E instruction is a load
- pcs_d, pcs_e, pcs_m  in  1  instruction in D/E/M writes PC
- pcsrc_w  in  1  PC write retiring in W
- branch_taken_e  in  1  branch resolved taken in E
- mem_req_m  in  1  M instruction accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- clr_stats  in  1  synchronous clear of statistics
- forward_ae, forward_be  out  2  operand select: 00 register file, 01 W result, 10 M result
- stall_f, stall_d, stall_e, stall_m  out  1  hold pipeline register
- flush_d, flush_e, flush_w  out  1  insert bubble into D/E/W register
- mem_abort  out  1  one-cycle pulse: memory must drop current access
- mem_err  out  1  sticky: a timeout abort occurred
- stall_cnt, flush_cnt  out  CNT_W  saturating statistics

## Operation
- Forward A: 10 if regwrite_m & wa3m==ra1e & ra1e!=PC_REG; else 01 if regwrite_w & wa3w==ra1e & ra1e!=PC_REG; else 00. M has priority. B identical with ra2e.
- ldr_stall = memtoreg_e & (ra1d==wa3e | ra2d==wa3e).
- pc_pend = pcs_d | pcs_e | pcs_m.
- mem_stall = mem_req_m & ~mem_ready & state!=S_ABORT.
- stall_m = stall_e = mem_stall; stall_d = mem_stall | ldr_stall; stall_f = mem_stall | ldr_stall | pc_pend.
- flush_w = mem_stall (prevents double writeback).
- When mem_stall=1, flush_d = flush_e = 0 (pipeline frozen; branch re-resolves after release).
- Otherwise flush_d = pc_pend | pcsrc_w | branch_taken_e; flush_e = ldr_stall | branch_taken_e.
- FSM states S_IDLE, S_WAIT, S_ABORT:
  - S_IDLE→S_WAIT on mem_stall.
  - S_WAIT→S_IDLE on mem_ready.
  - S_IDLE/S_WAIT→S_ABORT when a stalled cycle has wait_cnt==MEM_TIMEOUT-1.
  - S_ABORT→S_IDLE unconditionally.
- wait_cnt: width $clog2(MEM_TIMEOUT+1). Zero outside stalled cycles; increments each stalled cycle.
- S_ABORT: mem_abort=1 and no memory stall. mem_err set, cleared only by reset.
- stall_cnt increments on each cycle with stall_f=1. flush_cnt increments on each cycle with flush_d|flush_e=1. Both saturate at all-ones. clr_stats has priority over increment.

## Timing
- Forward, stall and flush outputs are combinational from inputs and state: zero latency.
- mem_abort and mem_err are registered-state driven.
- Memory stall is asserted in the same cycle mem_req_m & ~mem_ready is seen. It releases in the cycle mem_ready rises.
- Timeout gives exactly MEM_TIMEOUT stalled cycles, then one S_ABORT cycle with all memory stalls low.
- mem_ready arriving in the MEM_TIMEOUT-th stalled cycle ends the stall normally: no abort.
- Reset values: state S_IDLE, wait_cnt 0, mem_err 0, counters 0, mem_abort 0.
- While reset=1: stalls 0, flush_d/flush_e/flush_w 1, forwards 00.
- Reset mid-wait returns to S_IDLE immediately and asynchronously.

## Structure
- Package hazard_pkg holds:
  - state enum (S_IDLE, S_WAIT, S_ABORT)
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
- Sub-module hazard_sat_counter (CNT_W, inc, clr), instantiated twice for the statistics.

## Test plan
- wa3m=3, regwrite_m=1, wa3w=3, regwrite_w=1, ra1e=3 → forward_ae=10. Same with ra1e=15 → 00.
- memtoreg_e=1, wa3e=5, ra2d=5 → stall_f=stall_d=flush_e=1 for one cycle; stall_cnt +1.
- mem_req_m=1, mem_ready low 3 cycles then high → stall_f/d/e/m and flush_w high exactly 3 cycles; no abort; mem_err=0.
- MEM_TIMEOUT=4, mem_ready held low → 4 stalled cycles, then one cycle mem_abort=1 with stalls low; mem_err stays 1 until reset.
- branch_taken_e=1 during mem_stall → flush_d=flush_e=0; after mem_ready, flush_d=flush_e=1.
- Counters forced to all-ones stay saturated; clr_stats with simultaneous stall → counter 0; reset asserted in S_WAIT → S_IDLE, outputs at reset values.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ABORT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module hazard_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the F/D/E/M/W pipeline: forwarding, load-use and PC stalls,
// flushes, variable-latency memory freeze with timeout abort, and statistics.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned PC_REG      = 15,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ra1d,
  input  logic [REG_AW-1:0] ra2d,
  input  logic [REG_AW-1:0] ra1e,
  input  logic [REG_AW-1:0] ra2e,
  input  logic [REG_AW-1:0] wa3e,
  input  logic [REG_AW-1:0] wa3m,
  input  logic [REG_AW-1:0] wa3w,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              memtoreg_e,
  input  logic              pcs_d,
  input  logic              pcs_e,
  input  logic              pcs_m,
  input  logic              pcsrc_w,
  input  logic              branch_taken_e,
  input  logic              mem_req_m,
  input  logic              mem_ready,
  input  logic              clr_stats,
  output logic [1:0]        forward_ae,
  output logic [1:0]        forward_be,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic              mem_abort,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned       WCW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [REG_AW-1:0] PC_IDX    = REG_AW'(PC_REG);
  localparam logic [WCW-1:0]    WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           mem_err_q, mem_err_d;
  logic           ldr_stall, pc_pend, mem_stall;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] ra);
    if (ra == PC_IDX)                   return FWD_RF;
    else if (regwrite_m && wa3m == ra)  return FWD_M;
    else if (regwrite_w && wa3w == ra)  return FWD_W;
    else                                return FWD_RF;
  endfunction

  always_comb begin
    ldr_stall  = memtoreg_e && ((ra1d == wa3e) || (ra2d == wa3e));
    pc_pend    = pcs_d || pcs_e || pcs_m;
    mem_stall  = mem_req_m && !mem_ready && (state_q != S_ABORT);

    forward_ae = fwd_sel(ra1e);
    forward_be = fwd_sel(ra2e);
    stall_m    = mem_stall;
    stall_e    = mem_stall;
    stall_d    = mem_stall || ldr_stall;
    stall_f    = mem_stall || ldr_stall || pc_pend;
    flush_w    = mem_stall;
    // A frozen pipeline must not bubble D/E; the branch re-resolves once memory releases.
    flush_d    = !mem_stall && (pc_pend || pcsrc_w || branch_taken_e);
    flush_e    = !mem_stall && (ldr_stall || branch_taken_e);

    if (reset) begin
      forward_ae = FWD_RF;
      forward_be = FWD_RF;
      stall_m    = 1'b0;
      stall_e    = 1'b0;
      stall_d    = 1'b0;
      stall_f    = 1'b0;
      flush_w    = 1'b1;
      flush_d    = 1'b1;
      flush_e    = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    if (mem_stall) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (mem_stall) begin
          state_d = (wait_cnt_q == WAIT_LAST) ? S_ABORT : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_stall && (wait_cnt_q == WAIT_LAST)) begin
          state_d = S_ABORT;
        end else if (mem_ready) begin
          state_d = S_IDLE;
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    mem_err_d = mem_err_q || (state_d == S_ABORT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_abort = (state_q == S_ABORT);
  assign mem_err   = mem_err_q;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_f),
    .clr   (clr_stats),
    .cnt   (stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_d || flush_e),
    .clr   (clr_stats),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
  logic       regwrite_m, regwrite_w, memtoreg_e;
  logic       pcs_d, pcs_e, pcs_m, pcsrc_w, branch_taken_e;
  logic       mem_req_m, mem_ready, clr_stats;
  logic [1:0] forward_ae, forward_be;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic       mem_abort, mem_err;
  logic [3:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(
    .REG_AW(4), .PC_REG(15), .MEM_TIMEOUT(4), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .ra1d(ra1d), .ra2d(ra2d), .ra1e(ra1e), .ra2e(ra2e),
    .wa3e(wa3e), .wa3m(wa3m), .wa3w(wa3w),
    .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .memtoreg_e(memtoreg_e),
    .pcs_d(pcs_d), .pcs_e(pcs_e), .pcs_m(pcs_m), .pcsrc_w(pcsrc_w),
    .branch_taken_e(branch_taken_e), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .clr_stats(clr_stats),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .mem_abort(mem_abort), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic       rm, rw, mtr, pd, pe, pm, pw, bt;
    logic [1:0] fa, fb;
    logic       sf, sd, fd, fe;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(
    input logic [3:0] a1d, a2d, a1e, a2e, w3e, w3m, w3w,
    input logic rm, rw, mtr, pd, pe, pm, pw, bt,
    input logic [1:0] fa, fb, input logic sf, sd, fd, fe);
    vec_t v;
    v.ra1d = a1d; v.ra2d = a2d; v.ra1e = a1e; v.ra2e = a2e;
    v.wa3e = w3e; v.wa3m = w3m; v.wa3w = w3w;
    v.rm = rm; v.rw = rw; v.mtr = mtr; v.pd = pd; v.pe = pe; v.pm = pm; v.pw = pw; v.bt = bt;
    v.fa = fa; v.fb = fb; v.sf = sf; v.sd = sd; v.fd = fd; v.fe = fe;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    ra1d = 0; ra2d = 0; ra1e = 0; ra2e = 0; wa3e = 0; wa3m = 0; wa3w = 0;
    regwrite_m = 0; regwrite_w = 0; memtoreg_e = 0;
    pcs_d = 0; pcs_e = 0; pcs_m = 0; pcsrc_w = 0; branch_taken_e = 0;
    mem_req_m = 0; mem_ready = 0; clr_stats = 0;
  endtask

  task automatic clear_stats();
    @(negedge clk); idle(); clr_stats = 1;
    @(negedge clk); clr_stats = 0;
  endtask

  task automatic chk_mem_stall(input string name, input logic exp);
    chk({name, ".stall_f"}, stall_f, exp);
    chk({name, ".stall_d"}, stall_d, exp);
    chk({name, ".stall_e"}, stall_e, exp);
    chk({name, ".stall_m"}, stall_m, exp);
    chk({name, ".flush_w"}, flush_w, exp);
  endtask

  initial begin
    //          ra1d ra2d ra1e ra2e wa3e wa3m wa3w rm rw mt pd pe pm pw bt  fa     fb    sf sd fd fe
    vecs[0]  = mk(0, 0, 3,  0, 0, 3, 3,  1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 15, 0, 0, 15,15, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 7,  7, 0, 7, 7,  0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 9,  2, 0, 2, 9,  1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 4,  4, 0, 4, 4,  0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[5]  = mk(1, 5, 0,  0, 5, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 1);
    vecs[6]  = mk(1, 5, 0,  0, 5, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[7]  = mk(1, 2, 0,  0, 5, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1, 0);
    vecs[8]  = mk(1, 2, 0,  0, 5, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    vecs[9]  = mk(1, 2, 0,  0, 5, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1);
    vecs[10] = mk(1, 2, 0,  0, 1, 0, 0,  0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 1, 1, 1);

    idle();
    reset = 1;
    ra1e = 3; wa3m = 3; regwrite_m = 1; mem_req_m = 1;
    #2;
    chk("rst.forward_ae", forward_ae, 0);
    chk("rst.stall_f", stall_f, 0);
    chk("rst.stall_m", stall_m, 0);
    chk("rst.flush_d", flush_d, 1);
    chk("rst.flush_e", flush_e, 1);
    chk("rst.flush_w", flush_w, 1);
    chk("rst.mem_abort", mem_abort, 0);
    chk("rst.mem_err", mem_err, 0);
    chk("rst.stall_cnt", stall_cnt, 0);
    chk("rst.flush_cnt", flush_cnt, 0);
    @(negedge clk); idle(); reset = 0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      ra1d = vecs[i].ra1d; ra2d = vecs[i].ra2d; ra1e = vecs[i].ra1e; ra2e = vecs[i].ra2e;
      wa3e = vecs[i].wa3e; wa3m = vecs[i].wa3m; wa3w = vecs[i].wa3w;
      regwrite_m = vecs[i].rm; regwrite_w = vecs[i].rw; memtoreg_e = vecs[i].mtr;
      pcs_d = vecs[i].pd; pcs_e = vecs[i].pe; pcs_m = vecs[i].pm;
      pcsrc_w = vecs[i].pw; branch_taken_e = vecs[i].bt;
      #1;
      chk($sformatf("vec%0d.forward_ae", i), forward_ae, vecs[i].fa);
      chk($sformatf("vec%0d.forward_be", i), forward_be, vecs[i].fb);
      chk($sformatf("vec%0d.stall_f", i), stall_f, vecs[i].sf);
      chk($sformatf("vec%0d.stall_d", i), stall_d, vecs[i].sd);
      chk($sformatf("vec%0d.flush_d", i), flush_d, vecs[i].fd);
      chk($sformatf("vec%0d.flush_e", i), flush_e, vecs[i].fe);
      chk($sformatf("vec%0d.stall_e", i), stall_e, 0);
      chk($sformatf("vec%0d.flush_w", i), flush_w, 0);
    end

    // Single load-use cycle counts once in both statistics.
    clear_stats();
    memtoreg_e = 1; wa3e = 5; ra2d = 5; ra1d = 1;
    #1;
    chk("ldr.stall_f", stall_f, 1);
    chk("ldr.flush_e", flush_e, 1);
    @(negedge clk); idle(); #1;
    chk("ldr.stall_f_after", stall_f, 0);
    chk("ldr.stall_cnt", stall_cnt, 1);
    chk("ldr.flush_cnt", flush_cnt, 1);

    // Three not-ready cycles, ready arrives in the MEM_TIMEOUT-th cycle: no abort.
    clear_stats();
    mem_req_m = 1; mem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      chk_mem_stall($sformatf("wait%0d", c), 1);
      chk($sformatf("wait%0d.mem_abort", c), mem_abort, 0);
    end
    @(negedge clk); mem_ready = 1; #1;
    chk_mem_stall("ready", 0);
    chk("ready.mem_abort", mem_abort, 0);
    @(negedge clk); mem_req_m = 0; mem_ready = 0; #1;
    chk("ready.mem_abort_next", mem_abort, 0);
    chk("ready.mem_err", mem_err, 0);
    chk("ready.stall_cnt", stall_cnt, 3);
    chk("ready.flush_cnt", flush_cnt, 0);

    // Timeout: exactly four stalled cycles then one abort cycle with stalls low.
    @(negedge clk); mem_req_m = 1; mem_ready = 0;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      chk_mem_stall($sformatf("to%0d", c), 1);
      chk($sformatf("to%0d.mem_abort", c), mem_abort, 0);
    end
    @(negedge clk); #1;
    chk("abort.mem_abort", mem_abort, 1);
    chk("abort.mem_err", mem_err, 1);
    chk_mem_stall("abort", 0);
    mem_req_m = 0;
    @(negedge clk); #1;
    chk("post_abort.mem_abort", mem_abort, 0);
    chk("post_abort.mem_err", mem_err, 1);

    // Branch resolved during a memory freeze is held back until release.
    @(negedge clk); mem_req_m = 1; mem_ready = 0; branch_taken_e = 1; #1;
    chk("br_frozen.flush_d", flush_d, 0);
    chk("br_frozen.flush_e", flush_e, 0);
    chk("br_frozen.stall_f", stall_f, 1);
    @(negedge clk); mem_ready = 1; #1;
    chk("br_release.flush_d", flush_d, 1);
    chk("br_release.flush_e", flush_e, 1);
    chk("br_release.stall_d", stall_d, 0);
    chk("br_release.mem_err", mem_err, 1);

    // Saturation, then clear wins over a simultaneous increment.
    clear_stats();
    pcs_d = 1;
    repeat (20) @(negedge clk);
    #1;
    chk("sat.stall_cnt", stall_cnt, 15);
    chk("sat.flush_cnt", flush_cnt, 15);
    clr_stats = 1;
    @(negedge clk); clr_stats = 0; pcs_d = 0; #1;
    chk("clr.stall_cnt", stall_cnt, 0);
    chk("clr.flush_cnt", flush_cnt, 0);

    // Asynchronous reset while waiting on memory.
    @(negedge clk); idle(); mem_req_m = 1; mem_ready = 0;
    @(negedge clk); #1;
    chk("rw.stall_m", stall_m, 1);
    #1; reset = 1; ra1e = 3; wa3m = 3; regwrite_m = 1; #1;
    chk("rw.stall_m_rst", stall_m, 0);
    chk("rw.flush_w_rst", flush_w, 1);
    chk("rw.flush_d_rst", flush_d, 1);
    chk("rw.forward_ae_rst", forward_ae, 0);
    chk("rw.mem_err_rst", mem_err, 0);
    chk("rw.stall_cnt_rst", stall_cnt, 0);
    @(negedge clk); idle(); reset = 0;
    @(negedge clk); #1;
    chk("rw.mem_abort", mem_abort, 0);
    chk("rw.mem_err", mem_err, 0);
    chk("rw.stall_cnt", stall_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
